// File: rtl/vga_timing_receiver_pkg.sv
// vga_timing_receiver_pkg: 640x480@60 timing constants, receiver state encoding and saturating counters
package vga_timing_receiver_pkg;
  localparam logic [10:0] VGA_H_TOTAL     = 11'd800;
  localparam logic [9:0]  VGA_V_TOTAL     = 10'd525;
  localparam logic [10:0] VGA_H_ACT_START = 11'd160;
  localparam logic [9:0]  VGA_V_ACT_START = 10'd45;
  localparam logic [10:0] VGA_H_ACT       = 11'd640;
  localparam logic [9:0]  VGA_V_ACT       = 10'd480;
  localparam logic [1:0]  VGA_LOCK_FRAMES = 2'd2;
  localparam logic [10:0] VGA_TIMEOUT     = 11'd2047;
  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} rx_state_t;
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return &v ? v : v + 11'd1;
  endfunction
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return &v ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers HS/VS and flags their falling edges in the registered sample
module vga_sync_edge (
  input  logic VGA_Clk,
  input  logic Reset_N,
  input  logic VGA_HS,
  input  logic VGA_VS,
  output logic hs_fall,
  output logic vs_fall
);
  logic [1:0] hs_sr, vs_sr;
  always_ff @(posedge VGA_Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      hs_sr <= 2'b11;
      vs_sr <= 2'b11;
    end else begin
      hs_sr <= {hs_sr[0], VGA_HS};
      vs_sr <= {vs_sr[0], VGA_VS};
    end
  end
  assign hs_fall = hs_sr[1] & ~hs_sr[0];
  assign vs_fall = vs_sr[1] & ~vs_sr[0];
endmodule

// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: recovers VGA line/frame timing, locks to expected totals, emits active-area pixels
module vga_timing_receiver
  import vga_timing_receiver_pkg::*;
#(
  parameter logic [10:0] H_TOTAL     = VGA_H_TOTAL,
  parameter logic [9:0]  V_TOTAL     = VGA_V_TOTAL,
  parameter logic [10:0] H_ACT_START = VGA_H_ACT_START,
  parameter logic [9:0]  V_ACT_START = VGA_V_ACT_START,
  parameter logic [10:0] H_ACT       = VGA_H_ACT,
  parameter logic [9:0]  V_ACT       = VGA_V_ACT,
  parameter logic [1:0]  LOCK_FRAMES = VGA_LOCK_FRAMES,
  parameter logic [10:0] TIMEOUT     = VGA_TIMEOUT
) (
  input  logic        VGA_Clk,
  input  logic        Reset_N,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [7:0]  VGA_Red,
  input  logic [7:0]  VGA_Green,
  input  logic [7:0]  VGA_Blue,
  output logic        Pixel_Valid,
  output logic [9:0]  Pixel_X,
  output logic [9:0]  Pixel_Y,
  output logic [23:0] Pixel_Data,
  output logic        Line_Start,
  output logic        Frame_Start,
  output logic        Locked,
  output logic        Sync_Error,
  output logic [10:0] Measured_H_Total,
  output logic [9:0]  Measured_V_Total
);
  rx_state_t state, state_nx;
  logic [1:0] good, good_nx;
  logic hs_fall, vs_fall, line_bad, h_bad, f_bad, timeout, in_win, sync_err, lock_nx, pix_ok;
  logic [10:0] h_cnt, h_pos;
  logic [9:0] v_reg, v_pos, v_meas;
  logic [23:0] rgb_q;
  vga_sync_edge u_edge (
    .VGA_Clk(VGA_Clk),
    .Reset_N(Reset_N),
    .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS),
    .hs_fall(hs_fall),
    .vs_fall(vs_fall)
  );
  // h_cnt/v_reg already hold the length of the line/frame that a fall terminates
  always_comb begin
    h_pos = hs_fall ? '0 : h_cnt;
    v_meas = sat_inc10(v_reg);
    v_pos = vs_fall ? '0 : hs_fall ? v_meas : v_reg;
    h_bad = hs_fall && h_cnt != H_TOTAL;
    f_bad = v_meas != V_TOTAL || line_bad || h_bad;
    timeout = h_pos >= TIMEOUT;
    in_win = h_pos >= H_ACT_START && h_pos < H_ACT_START + H_ACT &&
             v_pos >= V_ACT_START && v_pos < V_ACT_START + V_ACT;
  end
  always_ff @(posedge VGA_Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      h_cnt <= '0;
      v_reg <= '0;
      line_bad <= 1'b0;
      rgb_q <= '0;
    end else begin
      h_cnt <= sat_inc11(h_pos);
      v_reg <= v_pos;
      line_bad <= !vs_fall && (line_bad || h_bad);
      rgb_q <= {VGA_Red, VGA_Green, VGA_Blue};
    end
  end
  always_ff @(posedge VGA_Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= SEARCH;
      good <= '0;
    end else begin
      state <= state_nx;
      good <= good_nx;
    end
  end
  always_comb begin
    state_nx = state;
    good_nx = good;
    if (timeout) begin
      state_nx = SEARCH;
      good_nx = '0;
    end else begin
      unique case (state)
        SEARCH: if (vs_fall) begin
          state_nx = ACQUIRE;
          good_nx = '0;
        end
        ACQUIRE: if (vs_fall) begin
          good_nx = f_bad ? '0 : good + 2'd1;
          state_nx = !f_bad && good + 2'd1 == LOCK_FRAMES ? LOCKED : ACQUIRE;
        end
        LOCKED: if (h_bad || (vs_fall && f_bad)) begin
          state_nx = ACQUIRE;
          good_nx = '0;
        end
        default: state_nx = SEARCH;
      endcase
    end
  end
  always_comb begin
    sync_err = state == LOCKED && !timeout && (h_bad || (vs_fall && f_bad));
    lock_nx = state_nx == LOCKED;
    pix_ok = lock_nx && in_win;
  end
  always_ff @(posedge VGA_Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      Pixel_Valid <= 1'b0;
      Pixel_X <= '0;
      Pixel_Y <= '0;
      Pixel_Data <= '0;
      Line_Start <= 1'b0;
      Frame_Start <= 1'b0;
      Locked <= 1'b0;
      Sync_Error <= 1'b0;
      Measured_H_Total <= '0;
      Measured_V_Total <= '0;
    end else begin
      Pixel_Valid <= pix_ok;
      Pixel_X <= pix_ok ? 10'(h_pos - H_ACT_START) : '0;
      Pixel_Y <= pix_ok ? v_pos - V_ACT_START : '0;
      Pixel_Data <= pix_ok ? rgb_q : '0;
      Line_Start <= hs_fall;
      Frame_Start <= vs_fall;
      Locked <= lock_nx;
      Sync_Error <= sync_err;
      Measured_H_Total <= hs_fall ? h_cnt : Measured_H_Total;
      Measured_V_Total <= vs_fall ? v_meas : Measured_V_Total;
    end
  end
endmodule
